amt_commit_release: RTL
=======================

# amt_commit_release

Architectural map table (AMT) with a 4-wide retirement port. It sits between the active-list retire stage and the speculative free list. For each committing instruction with a destination, it looks up the old physical mapping of the logical destination, installs the new physical register, and emits the old one as a release toward the free list's commit-push inputs. On a pipeline recovery it streams the full committed mapping, four entries per cycle, to the rename map table.

## Interface
Parameters:
- NUM_LOG_REGS, 32, number of logical registers; must be a multiple of 4 and ≥ 8.
- LOG_W, 5, log2(NUM_LOG_REGS).
- PHYS_W, 7, physical register index width.

Ports (N = 0..3; slot 0 is the oldest):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- recoverFlag_i  in  1  start a recovery walk.
- commitValidN_i  in  1  slot N retires this cycle.
- commitDestValidN_i  in  1  slot N has a register destination.
- commitLogDestN_i  in  LOG_W  logical destination of slot N.
- commitPhyDestN_i  in  PHYS_W  physical register allocated to slot N.
- releaseValidN_o  out  1  registered; slot N frees a register.
- releaseRegN_o  out  PHYS_W  registered; physical register freed by slot N.
- recoverValid_o  out  1  a walk beat is valid.
- recoverIdx_o  out  LOG_W  logical index of recoverMap0_o; beat k gives 4k.
- recoverMapN_o  out  PHYS_W  AMT[recoverIdx_o + N].
- recoverDone_o  out  1  last walk beat.

## Operation
Slot qualification:
- A slot is active when commitValidN_i & commitDestValidN_i.
- Slots with commitValid=0 are ignored even if their other fields are set.

Storage and reset:
- NUM_LOG_REGS × PHYS_W register array.
- Reset sets AMT[i] = i.
- The free list therefore initially holds physical registers NUM_LOG_REGS and above.

Old-mapping lookup:
- The old mapping for active slot N is the value of AMT[commitLogDestN_i] as seen by slot N, in program order.
- If an older active slot M < N in the same group has the same logical destination, the old mapping is commitPhyDestM_i from the youngest such M.
- Otherwise it is the current array value.

AMT update:
- At the clock edge, each logical register written in the group takes commitPhyDest of the youngest active slot targeting it.
- Same-address writes from older slots are discarded.

Release outputs:
- releaseValidN_o = slot N active.
- releaseRegN_o = old mapping of slot N when valid; 0 otherwise.
- No compaction; the free list compacts by slot.

Recovery FSM, two states:
- IDLE → WALK when recoverFlag_i is sampled high.
- Commits presented in the recoverFlag_i cycle are applied first, because they are older than the flush.
- In WALK, a beat counter k runs 0..NUM_LOG_REGS/4−1.
- Each beat: recoverValid_o = 1, recoverIdx_o = 4k, recoverMapN_o = AMT[4k+N].
- recoverDone_o = 1 on k = NUM_LOG_REGS/4−1; the next state is IDLE.
- recoverFlag_i during WALK restarts the walk at k = 0.
- Commit inputs during WALK are ignored: no AMT write, no release.

Reset mid-walk: returns to IDLE and re-initialises the AMT; all outputs are 0 in the following cycle.

## Timing
- Release latency is 1 cycle: commits at edge t produce releases that are valid in cycle t+1. Outputs are registered, with no combinational path from inputs.
- AMT writes from edge t are visible to commit lookups in cycle t+1. No bubbles: back-to-back groups to the same logical register release correctly.
- Walk latency: recoverFlag_i sampled at edge t gives the first beat in cycle t+1 and recoverDone_o in cycle t+NUM_LOG_REGS/4.
- recover* outputs are driven from the state, the counter, and an array read. recover* outputs are 0 in IDLE.
- Reset values: every output is 0, and the FSM is in IDLE.
- No handshake or backpressure. The free list accepts up to 4 pushes per cycle unconditionally.

## Configuration
AMT_ZERO_REG_EN:
- Defined: logical register 0 is hardwired zero. An active slot with commitLogDest = 0 does not write the AMT and releases its own commitPhyDest. It does not forward to younger slots, and AMT[0] stays 0 for all time.
- Undefined: logical register 0 is renamed like any other.

## Test plan
- Reset, then active slot 0 commits L3→P40: next cycle releaseValid0 = 1, releaseReg0 = 3; a walk then shows AMT[3] = 40.
- Same group: slot 0 commits L5→P33, slot 2 commits L5→P34, slot 1 valid without a destination: releases are slot 0 = 5 and slot 2 = 33, releaseValid1 = 0; afterwards AMT[5] = 34.
- Back-to-back: cycle t commits L7→P50, cycle t+1 commits L7→P51: release in t+1 = 7, release in t+2 = 50.
- recoverFlag_i with NUM_LOG_REGS = 32 after the scenarios above: 8 beats; beat 1 gives idx 4 with maps 4, 34, 6, 50/51 as applicable; recoverDone_o on beat 7; commits during the walk produce no release.
- recoverFlag_i asserted at beat 5 restarts at idx 0; reset asserted at beat 3 gives all outputs 0 and AMT[i] = i.
- With AMT_ZERO_REG_EN, commit L0→P60: release 60; the walk shows AMT[0] = 0.

Source files
------------

// File: rtl/amt_commit_release.sv
// Architectural map table with 4-wide commit, old-mapping release and a recovery walk.
// Optional define AMT_ZERO_REG_EN hardwires logical register 0 to zero.
module amt_commit_release #(
  parameter int NUM_LOG_REGS = 32,
  parameter int LOG_W        = 5,
  parameter int PHYS_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recoverFlag_i,
  input  logic              commitValid0_i,
  input  logic              commitValid1_i,
  input  logic              commitValid2_i,
  input  logic              commitValid3_i,
  input  logic              commitDestValid0_i,
  input  logic              commitDestValid1_i,
  input  logic              commitDestValid2_i,
  input  logic              commitDestValid3_i,
  input  logic [LOG_W-1:0]  commitLogDest0_i,
  input  logic [LOG_W-1:0]  commitLogDest1_i,
  input  logic [LOG_W-1:0]  commitLogDest2_i,
  input  logic [LOG_W-1:0]  commitLogDest3_i,
  input  logic [PHYS_W-1:0] commitPhyDest0_i,
  input  logic [PHYS_W-1:0] commitPhyDest1_i,
  input  logic [PHYS_W-1:0] commitPhyDest2_i,
  input  logic [PHYS_W-1:0] commitPhyDest3_i,
  output logic              releaseValid0_o,
  output logic              releaseValid1_o,
  output logic              releaseValid2_o,
  output logic              releaseValid3_o,
  output logic [PHYS_W-1:0] releaseReg0_o,
  output logic [PHYS_W-1:0] releaseReg1_o,
  output logic [PHYS_W-1:0] releaseReg2_o,
  output logic [PHYS_W-1:0] releaseReg3_o,
  output logic              recoverValid_o,
  output logic [LOG_W-1:0]  recoverIdx_o,
  output logic [PHYS_W-1:0] recoverMap0_o,
  output logic [PHYS_W-1:0] recoverMap1_o,
  output logic [PHYS_W-1:0] recoverMap2_o,
  output logic [PHYS_W-1:0] recoverMap3_o,
  output logic              recoverDone_o
);

  localparam int BEATS = NUM_LOG_REGS / 4;
  localparam int K_W   = LOG_W - 2;

  typedef enum logic {IDLE, WALK} state_t;

  state_t            state;
  logic [K_W-1:0]    beat;
  logic [PHYS_W-1:0] amt [NUM_LOG_REGS];

  logic              vld  [4];
  logic              dvld [4];
  logic [LOG_W-1:0]  logd [4];
  logic [PHYS_W-1:0] phyd [4];

  logic              active  [4];
  logic              wr      [4];
  logic [PHYS_W-1:0] old_map [4];

  logic              rel_vld [4];
  logic [PHYS_W-1:0] rel_reg [4];

  assign vld  = '{commitValid0_i, commitValid1_i, commitValid2_i, commitValid3_i};
  assign dvld = '{commitDestValid0_i, commitDestValid1_i, commitDestValid2_i, commitDestValid3_i};
  assign logd = '{commitLogDest0_i, commitLogDest1_i, commitLogDest2_i, commitLogDest3_i};
  assign phyd = '{commitPhyDest0_i, commitPhyDest1_i, commitPhyDest2_i, commitPhyDest3_i};

  // Old mapping = array value, overridden by the youngest older slot writing the same register.
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      active[n] = vld[n] & dvld[n] & (state == IDLE);
      wr[n]     = active[n];
`ifdef AMT_ZERO_REG_EN
      if (logd[n] == '0) wr[n] = 1'b0;
`endif
    end
    for (int unsigned n = 0; n < 4; n++) begin
      old_map[n] = amt[logd[n]];
      for (int unsigned m = 0; m < n; m++) begin
        if (wr[m] && (logd[m] == logd[n])) old_map[n] = phyd[m];
      end
`ifdef AMT_ZERO_REG_EN
      if (logd[n] == '0) old_map[n] = phyd[n];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LOG_REGS; i++) amt[i] <= PHYS_W'(i);
      for (int unsigned n = 0; n < 4; n++) begin
        rel_vld[n] <= 1'b0;
        rel_reg[n] <= '0;
      end
      state <= IDLE;
      beat  <= '0;
    end else begin
      // Ascending slot order: the youngest same-address write lands last and wins.
      for (int unsigned n = 0; n < 4; n++) begin
        rel_vld[n] <= active[n];
        rel_reg[n] <= active[n] ? old_map[n] : '0;
        if (wr[n]) amt[logd[n]] <= phyd[n];
      end
      case (state)
        IDLE: begin
          if (recoverFlag_i) begin
            state <= WALK;
            beat  <= '0;
          end
        end
        WALK: begin
          if (recoverFlag_i) begin
            beat <= '0;
          end else if (beat == K_W'(BEATS - 1)) begin
            state <= IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign releaseValid0_o = rel_vld[0];
  assign releaseValid1_o = rel_vld[1];
  assign releaseValid2_o = rel_vld[2];
  assign releaseValid3_o = rel_vld[3];
  assign releaseReg0_o   = rel_reg[0];
  assign releaseReg1_o   = rel_reg[1];
  assign releaseReg2_o   = rel_reg[2];
  assign releaseReg3_o   = rel_reg[3];

  assign recoverValid_o = (state == WALK);
  assign recoverIdx_o   = (state == WALK) ? {beat, 2'b00} : '0;
  assign recoverMap0_o  = (state == WALK) ? amt[{beat, 2'd0}] : '0;
  assign recoverMap1_o  = (state == WALK) ? amt[{beat, 2'd1}] : '0;
  assign recoverMap2_o  = (state == WALK) ? amt[{beat, 2'd2}] : '0;
  assign recoverMap3_o  = (state == WALK) ? amt[{beat, 2'd3}] : '0;
  assign recoverDone_o  = (state == WALK) && (beat == K_W'(BEATS - 1));

endmodule
